cmd_dispatch_queue: RTL and testbench
=====================================

Name: cmd_dispatch_queue

Overview:
- Timed command queue directly downstream of the distributed processor core.
- Captures each command the core emits on its command strobe into a FIFO.
- Holds each command until the core's qclk reaches the command's trigger timestamp, then issues it to the pulse/signal-generator stage as a one-cycle strobe.
- Gives the core a full flag for stalling, and raises sticky overflow and late error flags.

Parameters:
- CMD_WIDTH, 128: width of a command word; matches the core's command output.
- TIME_WIDTH, 32: width of the trigger timestamp held in cmd_in[TIME_WIDTH-1:0]; matches qclk width.
- DEPTH_LOG2, 4: FIFO depth = 2**DEPTH_LOG2 entries.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_in  input  CMD_WIDTH  command word from the core; bits [TIME_WIDTH-1:0] are the trigger time.
- cstrobe_in  input  1  push strobe from the core; one command per high cycle.
- qclk_in  input  TIME_WIDTH  current qclk value from the core; free-running and wrapping.
- clear_err  input  1  synchronous clear of overflow_err and late_err.
- cmd_out  output  CMD_WIDTH  issued command, full word including timestamp.
- cmd_valid  output  1  one-cycle strobe qualifying cmd_out.
- fifo_full  output  1  high when count == 2**DEPTH_LOG2; the core must not strobe while high.
- fifo_empty  output  1  high when count == 0.
- overflow_err  output  1  sticky; a push was dropped.
- late_err  output  1  sticky; a command was issued after its trigger time.

Behaviour:
- Reset (async assert, removal synchronous to clk):
  - Read pointer, write pointer and count are 0.
  - cmd_out = 0, cmd_valid = 0, fifo_full = 0, fifo_empty = 1, overflow_err = 0, late_err = 0.
  - Reset mid-operation discards all queued entries; no strobe is produced during reset or in the first cycle after it.
- Push:
  - On cstrobe_in, cmd_in is written at the write pointer, which then increments and wraps modulo depth.
  - If the FIFO is full and no pop occurs that cycle, the command is dropped, the pointer is unchanged and overflow_err is set.
  - If the FIFO is full and a pop occurs that same cycle, the push is accepted and count is unchanged.
- Head compare, evaluated each cycle when count > 0 on the registered head entry:
  - delta = qclk_in - head_time, computed modulo 2**TIME_WIDTH and interpreted as signed TIME_WIDTH.
  - delta == 0: on-time issue.
  - delta > 0 (i.e. 0 < delta < 2**(TIME_WIDTH-1)): late issue; also sets late_err.
  - delta < 0: hold; nothing is issued.
- Issue:
  - Registered: on the clock edge after the compare succeeds, cmd_out = head entry and cmd_valid = 1 for exactly one cycle.
  - The pop happens on that same edge.
  - At most one issue per cycle. Back-to-back entries with equal timestamps issue on consecutive cycles; the second is flagged late.
- Latency: a command pushed at edge N is at the head at N+1 at the earliest, and cmd_valid is high at N+2 at the earliest, provided its time has been reached.
- Output hold: cmd_out holds its last value when cmd_valid is low.
- Push on empty: the FIFO is not bypassed; the two-cycle minimum latency above applies.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Errors: clear_err clears both sticky flags. If clear_err coincides with a new error event in the same cycle, the set wins.
- FSM (tracks head status):
  - EMPTY: count == 0.
  - WAIT: head present, delta < 0.
  - ISSUE: compare succeeded; the next edge pops and issues.
  - Transitions: EMPTY→WAIT on push. WAIT→ISSUE on delta ≥ 0. ISSUE→WAIT if entries remain after the pop, else ISSUE→EMPTY.
- Flags: fifo_full and fifo_empty are registered and derived from the count after each edge.

Optional Feature:
DISPATCH_STATS_EN
- Defined:
  - Adds output issued_count (32 bits), incremented on every cmd_valid.
  - Adds output late_count (32 bits), incremented on every late issue.
  - Both reset to 0 and saturate at all-ones.
- Not defined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Push cmd with time 100 while qclk = 50, qclk incrementing by 1 per cycle → cmd_valid high exactly once, on the edge after qclk = 100; late_err stays 0.
- Push times 200, 200, 300 → issues on consecutive cycles at qclk 200 and 201 (second flagged, late_err = 1), then at qclk 300; clear_err then returns late_err to 0.
- Wrap case: qclk = 0xFFFFFFF0, push time 0x00000010 → held through the wrap, issued on the edge after qclk = 0x10, not late.
- Fill 16 entries with future times → fifo_full = 1; a 17th push sets overflow_err = 1 with count staying 16; a push in the same cycle as a pop is accepted with count staying 16.
- Push time 50 while qclk = 60 → issued 2 cycles after the push with late_err = 1.
- Queue 3 entries, then assert reset mid-wait → fifo_empty = 1, cmd_valid never asserts afterwards; with DISPATCH_STATS_EN defined, issued_count and late_count read 0.

Source files
------------

// File: rtl/cmd_dispatch_queue_if.sv
// Core-to-dispatch-queue bundle: master is the processor core, slave is cmd_dispatch_queue.
// issued_count/late_count are present only when DISPATCH_STATS_EN is defined.
interface cmd_dispatch_queue_if #(
  parameter int CMD_WIDTH  = 128,
  parameter int TIME_WIDTH = 32
);
  logic [CMD_WIDTH-1:0]  cmd_in;
  logic                  cstrobe_in;
  logic [TIME_WIDTH-1:0] qclk_in;
  logic                  clear_err;
  logic [CMD_WIDTH-1:0]  cmd_out;
  logic                  cmd_valid;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  overflow_err;
  logic                  late_err;
`ifdef DISPATCH_STATS_EN
  logic [31:0]           issued_count;
  logic [31:0]           late_count;

  modport master (
    output cmd_in, cstrobe_in, qclk_in, clear_err,
    input  cmd_out, cmd_valid, fifo_full, fifo_empty, overflow_err, late_err,
    input  issued_count, late_count
  );
  modport slave (
    input  cmd_in, cstrobe_in, qclk_in, clear_err,
    output cmd_out, cmd_valid, fifo_full, fifo_empty, overflow_err, late_err,
    output issued_count, late_count
  );
`else
  modport master (
    output cmd_in, cstrobe_in, qclk_in, clear_err,
    input  cmd_out, cmd_valid, fifo_full, fifo_empty, overflow_err, late_err
  );
  modport slave (
    input  cmd_in, cstrobe_in, qclk_in, clear_err,
    output cmd_out, cmd_valid, fifo_full, fifo_empty, overflow_err, late_err
  );
`endif
endinterface

// File: rtl/cmd_dispatch_queue.sv
// Timed command FIFO: issues the head one cycle after qclk reaches its timestamp (push-to-issue >= 2 cycles);
// core must not strobe while fifo_full, dropped pushes set overflow_err. DISPATCH_STATS_EN adds issue/late counters.
module cmd_dispatch_queue #(
  parameter int CMD_WIDTH  = 128,
  parameter int TIME_WIDTH = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  cmd_dispatch_queue_if.slave  bus
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LP_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_ISSUE} state_t;

  logic [CMD_WIDTH-1:0]  r_mem [DEPTH];
  logic [CMD_WIDTH-1:0]  r_head;
  logic [CMD_WIDTH-1:0]  r_cmd_out;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2-1:0] w_rd_ptr_nxt;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DEPTH_LOG2:0]   w_count_nxt;
  logic                  r_cmd_valid;
  logic                  r_fifo_full;
  logic                  r_fifo_empty;
  logic                  r_overflow_err;
  logic                  r_late_err;
  state_t                r_state;
  state_t                w_state;
  state_t                w_state_nxt;
  logic [TIME_WIDTH-1:0] w_delta;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_late;
  logic                  w_ovf;

  // Modular difference; its MSB is the sign of delta, so wrap-around is handled for free.
  assign w_delta = bus.qclk_in - r_head[TIME_WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // ISSUE comes from the live qclk compare and resolves on the closing edge,
  // so the state register itself only ever holds EMPTY or WAIT.
  always_comb begin
    w_state     = r_state;
    w_state_nxt = S_EMPTY;
    if (r_state == S_WAIT && !w_delta[TIME_WIDTH-1]) w_state = S_ISSUE;
    case (w_state)
      S_EMPTY: w_state_nxt = (r_count != '0) ? S_WAIT : S_EMPTY;
      S_ISSUE: w_state_nxt = (r_count > (DEPTH_LOG2+1)'(1)) ? S_WAIT : S_EMPTY;
      default: w_state_nxt = S_WAIT;
    endcase
  end

  always_comb begin
    w_pop        = (w_state == S_ISSUE);
    w_late       = w_pop && (w_delta != '0);
    w_ovf        = bus.cstrobe_in && (r_count == LP_FULL) && !w_pop;
    w_push       = bus.cstrobe_in && !w_ovf;
    w_rd_ptr_nxt = w_pop ? r_rd_ptr + DEPTH_LOG2'(1) : r_rd_ptr;
    w_count_nxt  = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + (DEPTH_LOG2+1)'(1);
    else if (w_pop && !w_push) w_count_nxt = r_count - (DEPTH_LOG2+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.cmd_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_head         <= '0;
      r_cmd_out      <= '0;
      r_cmd_valid    <= 1'b0;
      r_fifo_full    <= 1'b0;
      r_fifo_empty   <= 1'b1;
      r_overflow_err <= 1'b0;
      r_late_err     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_count      <= w_count_nxt;
      // Entries written on this edge are not visible yet; this is what gives the two-cycle minimum latency.
      r_head       <= r_mem[w_rd_ptr_nxt];
      r_cmd_valid  <= w_pop;
      if (w_pop) r_cmd_out <= r_head;
      r_fifo_full  <= (w_count_nxt == LP_FULL);
      r_fifo_empty <= (w_count_nxt == '0);
      if (w_ovf)              r_overflow_err <= 1'b1;
      else if (bus.clear_err) r_overflow_err <= 1'b0;
      if (w_late)             r_late_err <= 1'b1;
      else if (bus.clear_err) r_late_err <= 1'b0;
    end
  end

  assign bus.cmd_out      = r_cmd_out;
  assign bus.cmd_valid    = r_cmd_valid;
  assign bus.fifo_full    = r_fifo_full;
  assign bus.fifo_empty   = r_fifo_empty;
  assign bus.overflow_err = r_overflow_err;
  assign bus.late_err     = r_late_err;

`ifdef DISPATCH_STATS_EN
  logic [31:0] r_issued_count;
  logic [31:0] r_late_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_issued_count <= '0;
      r_late_count   <= '0;
    end else begin
      if (w_pop && r_issued_count != '1) r_issued_count <= r_issued_count + 32'd1;
      if (w_late && r_late_count != '1)  r_late_count   <= r_late_count + 32'd1;
    end
  end

  assign bus.issued_count = r_issued_count;
  assign bus.late_count   = r_late_count;
`endif
endmodule

// File: tb/tb_cmd_dispatch_queue.sv
// Randomised bench for cmd_dispatch_queue against a queue-of-timestamps reference model.
module tb_cmd_dispatch_queue;
  localparam int CW    = 128;
  localparam int TW    = 32;
  localparam int DL    = 4;
  localparam int DEPTH = 16;

  typedef struct { logic [CW-1:0] dat; int pe; } ent_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: pending commands with the edge they were pushed on.
  ent_t          mq[$];
  int            edge_n;
  logic [CW-1:0] exp_out;
  logic          exp_vld, exp_ovf, exp_late, exp_full, exp_empty;
  logic [31:0]   exp_icnt, exp_lcnt;

  cmd_dispatch_queue_if #(.CMD_WIDTH(CW), .TIME_WIDTH(TW)) bus ();
  cmd_dispatch_queue #(.CMD_WIDTH(CW), .TIME_WIDTH(TW), .DEPTH_LOG2(DL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] mk(input logic [TW-1:0] t);
    return {$urandom, $urandom, $urandom, t};
  endfunction

  task automatic model_reset();
    mq.delete();
    edge_n = 0; exp_out = '0; exp_vld = 0; exp_ovf = 0; exp_late = 0;
    exp_full = 0; exp_empty = 1; exp_icnt = '0; exp_lcnt = '0;
  endtask

  task automatic do_reset();
    bus.cstrobe_in = 0; bus.clear_err = 0;
    #2 reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One clock: head is eligible once it was pushed before the latest edge; issue when signed delta >= 0.
  task automatic cycle();
    logic iss, lt, ovf;
    logic [TW-1:0] d;
    iss = 0; lt = 0; d = '0;
    if (mq.size() > 0 && mq[0].pe < edge_n) begin
      d = bus.qclk_in - mq[0].dat[TW-1:0];
      if ($signed(d) >= 0) begin iss = 1; lt = (d != 0); end
    end
    ovf = bus.cstrobe_in && (mq.size() >= DEPTH) && !iss;
    @(posedge clk);
    edge_n++;
    exp_vld = iss;
    if (iss) begin
      exp_out = mq[0].dat;
      mq.delete(0);
      if (exp_icnt != 32'hFFFF_FFFF) exp_icnt++;
      if (lt && exp_lcnt != 32'hFFFF_FFFF) exp_lcnt++;
    end
    if (bus.cstrobe_in && !ovf) mq.push_back('{dat: bus.cmd_in, pe: edge_n});
    if (ovf) exp_ovf = 1; else if (bus.clear_err) exp_ovf = 0;
    if (lt)  exp_late = 1; else if (bus.clear_err) exp_late = 0;
    exp_full  = (mq.size() == DEPTH);
    exp_empty = (mq.size() == 0);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (bus.cmd_valid !== 1'b0) begin n_err++; $display("FAIL reset.valid got %b want 0", bus.cmd_valid); end
    n_vec++; if (bus.cmd_out !== '0) begin n_err++; $display("FAIL reset.cmd_out got %h want 0", bus.cmd_out); end
    n_vec++; if (bus.fifo_full !== 1'b0) begin n_err++; $display("FAIL reset.full got %b want 0", bus.fifo_full); end
    n_vec++; if (bus.fifo_empty !== 1'b1) begin n_err++; $display("FAIL reset.empty got %b want 1", bus.fifo_empty); end
    n_vec++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL reset.ovf got %b want 0", bus.overflow_err); end
    n_vec++; if (bus.late_err !== 1'b0) begin n_err++; $display("FAIL reset.late got %b want 0", bus.late_err); end
`ifdef DISPATCH_STATS_EN
    n_vec++; if (bus.issued_count !== 32'd0) begin n_err++; $display("FAIL reset.icnt got %0d want 0", bus.issued_count); end
    n_vec++; if (bus.late_count !== 32'd0) begin n_err++; $display("FAIL reset.lcnt got %0d want 0", bus.late_count); end
`endif
    reset = 1'b0;
    cycle();
    n_vec++; if (bus.cmd_valid !== 1'b0) begin n_err++; $display("FAIL reset.post_valid got %b want 0", bus.cmd_valid); end
  endtask

  task automatic test_on_time();
    logic [TW-1:0] q, hit_q;
    int hits;
    do_reset();
    q = 50; hits = 0; hit_q = '0;
    bus.qclk_in = q; bus.cmd_in = mk(100); bus.cstrobe_in = 1;
    cycle();
    bus.cstrobe_in = 0;
    for (int i = 0; i < 70; i++) begin
      q = q + 1; bus.qclk_in = q;
      cycle();
      n_vec++; if (bus.cmd_valid !== exp_vld) begin n_err++; $display("FAIL on_time.valid i=%0d got %b want %b", i, bus.cmd_valid, exp_vld); end
      if (bus.cmd_valid === 1'b1) begin
        hits++; hit_q = q;
        n_vec++; if (bus.cmd_out !== exp_out) begin n_err++; $display("FAIL on_time.cmd_out got %h want %h", bus.cmd_out, exp_out); end
      end
    end
    n_vec++; if (hits != 1 || hit_q != 32'd100) begin n_err++; $display("FAIL on_time.issue hits=%0d at qclk=%0d want 1 at 100", hits, hit_q); end
    n_vec++; if (bus.late_err !== 1'b0) begin n_err++; $display("FAIL on_time.late got %b want 0", bus.late_err); end
  endtask

  task automatic test_equal_times();
    logic [TW-1:0] q;
    logic [TW-1:0] hq[$];
    logic [TW-1:0] want [3];
    do_reset();
    want[0] = 200; want[1] = 201; want[2] = 300;
    q = 150; bus.qclk_in = q; bus.cstrobe_in = 1;
    bus.cmd_in = mk(200); cycle();
    bus.cmd_in = mk(200); cycle();
    bus.cmd_in = mk(300); cycle();
    bus.cstrobe_in = 0;
    for (int i = 0; i < 160; i++) begin
      q = q + 1; bus.qclk_in = q;
      cycle();
      n_vec++; if (bus.cmd_valid !== exp_vld || bus.cmd_out !== exp_out) begin n_err++; $display("FAIL equal.issue q=%0d got %b/%h want %b/%h", q, bus.cmd_valid, bus.cmd_out, exp_vld, exp_out); end
      if (bus.cmd_valid === 1'b1) begin
        hq.push_back(q);
        if (hq.size() == 1) begin n_vec++; if (bus.late_err !== 1'b0) begin n_err++; $display("FAIL equal.late_first got %b want 0", bus.late_err); end end
        if (hq.size() == 2) begin n_vec++; if (bus.late_err !== 1'b1) begin n_err++; $display("FAIL equal.late_second got %b want 1", bus.late_err); end end
      end
    end
    n_vec++;
    if (hq.size() != 3) begin n_err++; $display("FAIL equal.count got %0d want 3", hq.size()); end
    else if (hq[0] != want[0] || hq[1] != want[1] || hq[2] != want[2]) begin
      n_err++; $display("FAIL equal.times got %0d,%0d,%0d want 200,201,300", hq[0], hq[1], hq[2]);
    end
    bus.clear_err = 1; cycle(); bus.clear_err = 0;
    n_vec++; if (bus.late_err !== 1'b0) begin n_err++; $display("FAIL equal.clear got %b want 0", bus.late_err); end
  endtask

  task automatic test_wrap();
    logic [TW-1:0] q, hit_q;
    int hits;
    do_reset();
    q = 32'hFFFF_FFF0; hits = 0; hit_q = '0;
    bus.qclk_in = q; bus.cmd_in = mk(32'h10); bus.cstrobe_in = 1;
    cycle();
    bus.cstrobe_in = 0;
    for (int i = 0; i < 40; i++) begin
      q = q + 1; bus.qclk_in = q;
      cycle();
      n_vec++; if (bus.cmd_valid !== exp_vld) begin n_err++; $display("FAIL wrap.valid q=%h got %b want %b", q, bus.cmd_valid, exp_vld); end
      if (bus.cmd_valid === 1'b1) begin hits++; hit_q = q; end
    end
    n_vec++; if (hits != 1 || hit_q != 32'h10) begin n_err++; $display("FAIL wrap.issue hits=%0d at %h want 1 at 10", hits, hit_q); end
    n_vec++; if (bus.late_err !== 1'b0) begin n_err++; $display("FAIL wrap.late got %b want 0", bus.late_err); end
  endtask

  task automatic test_overflow();
    int hits;
    do_reset();
    bus.qclk_in = 0; bus.cstrobe_in = 1;
    for (int i = 0; i < DEPTH; i++) begin bus.cmd_in = mk(TW'(1000 + i)); cycle(); end
    bus.cstrobe_in = 0; cycle();
    n_vec++; if (bus.fifo_full !== 1'b1 || bus.fifo_empty !== 1'b0) begin n_err++; $display("FAIL ovf.full got %b/%b want 1/0", bus.fifo_full, bus.fifo_empty); end
    n_vec++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL ovf.pre got %b want 0", bus.overflow_err); end
    bus.cstrobe_in = 1; bus.cmd_in = mk(2000); cycle(); bus.cstrobe_in = 0;
    n_vec++; if (bus.overflow_err !== 1'b1 || bus.fifo_full !== 1'b1) begin n_err++; $display("FAIL ovf.drop got ovf=%b full=%b want 1/1", bus.overflow_err, bus.fifo_full); end
    bus.clear_err = 1; cycle(); bus.clear_err = 0;
    n_vec++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL ovf.clear got %b want 0", bus.overflow_err); end
    bus.qclk_in = 1000; bus.cstrobe_in = 1; bus.cmd_in = mk(3000); cycle(); bus.cstrobe_in = 0;
    n_vec++; if (bus.cmd_valid !== 1'b1 || bus.cmd_out[TW-1:0] !== 32'd1000) begin n_err++; $display("FAIL ovf.pop got %b/%0d want 1/1000", bus.cmd_valid, bus.cmd_out[TW-1:0]); end
    n_vec++; if (bus.fifo_full !== 1'b1 || bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL ovf.pushpop got full=%b ovf=%b want 1/0", bus.fifo_full, bus.overflow_err); end
    bus.qclk_in = 0; cycle();
    n_vec++; if (bus.fifo_full !== 1'b1) begin n_err++; $display("FAIL ovf.still_full got %b want 1", bus.fifo_full); end
    bus.qclk_in = 5000; hits = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_vec++; if (bus.cmd_valid !== exp_vld || bus.cmd_out !== exp_out) begin n_err++; $display("FAIL ovf.drain i=%0d got %b/%h want %b/%h", i, bus.cmd_valid, bus.cmd_out, exp_vld, exp_out); end
      if (bus.cmd_valid === 1'b1) hits++;
    end
    n_vec++; if (hits != DEPTH || bus.cmd_out[TW-1:0] !== 32'd3000) begin n_err++; $display("FAIL ovf.drained got %0d last %0d want 16 last 3000", hits, bus.cmd_out[TW-1:0]); end
  endtask

  task automatic test_late_push();
    do_reset();
    bus.qclk_in = 60; bus.cmd_in = mk(50); bus.cstrobe_in = 1;
    cycle();
    bus.cstrobe_in = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_vec++; if (bus.cmd_valid !== (i == 1)) begin n_err++; $display("FAIL late_push.valid cyc %0d got %b want %b", i + 1, bus.cmd_valid, (i == 1)); end
    end
    n_vec++; if (bus.late_err !== 1'b1) begin n_err++; $display("FAIL late_push.late got %b want 1", bus.late_err); end
  endtask

  task automatic test_reset_mid_wait();
    logic [TW-1:0] q;
    do_reset();
    bus.qclk_in = 5; bus.cstrobe_in = 1; bus.cmd_in = mk(0); cycle();
    bus.qclk_in = 0;
    bus.cmd_in = mk(20); cycle();
    bus.cmd_in = mk(30); cycle();
    bus.cmd_in = mk(40); cycle();
    bus.cstrobe_in = 0;
    repeat (2) cycle();
    #2 reset = 1'b1;
    #1;
    n_vec++; if (bus.fifo_empty !== 1'b1 || bus.cmd_valid !== 1'b0) begin n_err++; $display("FAIL midreset.async got empty=%b valid=%b want 1/0", bus.fifo_empty, bus.cmd_valid); end
`ifdef DISPATCH_STATS_EN
    n_vec++; if (bus.issued_count !== 32'd0 || bus.late_count !== 32'd0) begin n_err++; $display("FAIL midreset.stats got %0d/%0d want 0/0", bus.issued_count, bus.late_count); end
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    q = 0;
    for (int i = 0; i < 70; i++) begin
      bus.qclk_in = q; q = q + 1;
      cycle();
      n_vec++; if (bus.cmd_valid !== 1'b0) begin n_err++; $display("FAIL midreset.valid q=%0d got %b want 0", q, bus.cmd_valid); end
    end
    n_vec++; if (bus.fifo_empty !== 1'b1 || bus.late_err !== 1'b0) begin n_err++; $display("FAIL midreset.end got empty=%b late=%b want 1/0", bus.fifo_empty, bus.late_err); end
  endtask

  task automatic test_random();
    logic [TW-1:0] qc;
    do_reset();
    qc = $urandom;
    for (int i = 0; i < 1500; i++) begin
      qc = qc + TW'($urandom_range(0, 2));
      if ($urandom_range(0, 99) == 0) qc = $urandom;
      bus.qclk_in    = qc;
      bus.cstrobe_in = ($urandom_range(0, 99) < 45);
      bus.cmd_in     = mk(qc + TW'($urandom_range(0, 30)) - TW'(4));
      bus.clear_err  = ($urandom_range(0, 99) < 4);
      cycle();
      n_vec++; if (bus.cmd_valid !== exp_vld) begin n_err++; $display("FAIL rand.valid i=%0d got %b want %b", i, bus.cmd_valid, exp_vld); end
      n_vec++; if (bus.cmd_out !== exp_out) begin n_err++; $display("FAIL rand.cmd_out i=%0d got %h want %h", i, bus.cmd_out, exp_out); end
      n_vec++; if (bus.fifo_full !== exp_full || bus.fifo_empty !== exp_empty) begin n_err++; $display("FAIL rand.flags i=%0d got %b/%b want %b/%b", i, bus.fifo_full, bus.fifo_empty, exp_full, exp_empty); end
      n_vec++; if (bus.overflow_err !== exp_ovf) begin n_err++; $display("FAIL rand.ovf i=%0d got %b want %b", i, bus.overflow_err, exp_ovf); end
      n_vec++; if (bus.late_err !== exp_late) begin n_err++; $display("FAIL rand.late i=%0d got %b want %b", i, bus.late_err, exp_late); end
`ifdef DISPATCH_STATS_EN
      n_vec++; if (bus.issued_count !== exp_icnt || bus.late_count !== exp_lcnt) begin n_err++; $display("FAIL rand.stats i=%0d got %0d/%0d want %0d/%0d", i, bus.issued_count, bus.late_count, exp_icnt, exp_lcnt); end
`endif
    end
    bus.cstrobe_in = 0; bus.clear_err = 0;
  endtask

  initial begin
    bus.cmd_in = '0; bus.cstrobe_in = 0; bus.qclk_in = '0; bus.clear_err = 0;
    test_reset();
    test_on_time();
    test_equal_times();
    test_wrap();
    test_overflow();
    test_late_push();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
